// File: rtl/pixel_packer_axis_pkg.sv
// rtl/pixel_packer_axis_pkg.sv - shared widths, state encoding and keep helper for the pixel packer
package pixel_packer_axis_pkg;

  localparam int PIX_W  = 8;
  localparam int AXIS_W = 32;
  localparam int LANES  = 4;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_PACK_ENC  = 2'd1;
  localparam logic [1:0] ST_DRAIN_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_PACK  = ST_PACK_ENC,
    ST_DRAIN = ST_DRAIN_ENC
  } state_e;

  // Byte-valid mask for a word whose highest written lane is last_lane.
  function automatic logic [LANES-1:0] keep_mask(input logic [1:0] last_lane);
    case (last_lane)
      2'd0:    keep_mask = 4'b0001;
      2'd1:    keep_mask = 4'b0011;
      2'd2:    keep_mask = 4'b0111;
      default: keep_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/pixel_packer_axis_fifo.sv
// rtl/pixel_packer_axis_fifo.sv - sync_fifo_fwft: first-word-fall-through FIFO with full/empty flags
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_wr, do_rd;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign do_rd = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign do_wr = wr_en && (!full || do_rd);

  // Head entry is presented straight from storage; forced to zero when nothing is held.
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/pixel_packer_axis.sv
// rtl/pixel_packer_axis.sv - packs 8-bit pixels into 32-bit AXI4-Stream words with tlast/tkeep per frame
module pixel_packer_axis
  import pixel_packer_axis_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_frame_pix,
  input  logic [PIX_W-1:0]  i_pix,
  input  logic              i_pix_valid,
  output logic [AXIS_W-1:0] m_axis_tdata,
  output logic [LANES-1:0]  m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overflow
);

  localparam int FW = AXIS_W + LANES + 1;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        lane_q, lane_d;
  logic [AXIS_W-1:0] asm_q, asm_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;

  logic [AXIS_W-1:0] word_w;
  logic              last_pix;
  logic              push;
  logic              pop;
  logic [FW-1:0]     push_word;
  logic [FW-1:0]     head_word;
  logic              fifo_full, fifo_empty;

  assign last_pix  = ((cnt_q + LEN_W'(1)) == len_q);
  assign push_word = {last_pix, keep_mask(lane_q), word_w};
  assign pop       = m_axis_tvalid && m_axis_tready;

  always_comb begin
    word_w = asm_q;
    word_w[lane_q*PIX_W +: PIX_W] = i_pix;
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    lane_d  = lane_q;
    asm_d   = asm_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start && (i_frame_pix != '0)) begin
          len_d   = i_frame_pix;
          cnt_d   = '0;
          lane_d  = '0;
          asm_d   = '0;
          ovf_d   = 1'b0;
          state_d = ST_PACK;
        end
      end
      ST_PACK: begin
        if (i_pix_valid) begin
          lane_d = lane_q + 2'd1;
          cnt_d  = cnt_q + LEN_W'(1);
          if ((lane_q == 2'd3) || last_pix) begin
            push  = 1'b1;
            asm_d = '0;
          end else begin
            asm_d = word_w;
          end
          if (last_pix) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // An empty FIFO here means the tlast word was dropped on overflow.
        if (pop && m_axis_tlast) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (fifo_empty) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (push && fifo_full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      lane_q  <= '0;
      asm_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      lane_q  <= lane_d;
      asm_q   <= asm_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (push_word),
    .rd_en   (pop),
    .rd_data (head_word),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tlast  = head_word[FW-1];
  assign m_axis_tkeep  = head_word[AXIS_W +: LANES];
  assign m_axis_tdata  = head_word[AXIS_W-1:0];
  assign o_busy        = (state_q != ST_IDLE);
  assign o_done        = done_q;
  assign o_overflow    = ovf_q;

endmodule

// File: tb/tb_pixel_packer_axis.sv
// tb/tb_pixel_packer_axis.sv - scoreboard bench for pixel_packer_axis with a frame-level reference model
module tb_pixel_packer_axis;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic [19:0] i_frame_pix;
  logic [7:0]  i_pix;
  logic        i_pix_valid;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        o_busy;
  logic        o_done;
  logic        o_overflow;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  word_t      exp_q[$];
  logic [7:0] pix_buf[$];
  int tests = 0;
  int fails = 0;
  int done_seen = 0;
  int done_exp = 0;
  int cyc = 0;
  int hs_cyc = -10;
  int ready_mode = 0;
  bit stall_q = 0;
  logic [36:0] stall_word;
  word_t w_mon;

  pixel_packer_axis #(.FIFO_DEPTH(4), .LEN_W(20)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (i_start),
    .i_frame_pix   (i_frame_pix),
    .i_pix         (i_pix),
    .i_pix_valid   (i_pix_valid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_overflow    (o_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: split pixel list into 4-byte little-endian words, zero padded; keep only the first 'limit'.
  function automatic void expect_frame(input int limit);
    int n = pix_buf.size();
    int idx = 0;
    for (int b = 0; b < n; b += 4) begin
      word_t w;
      int cnt = (n - b < 4) ? (n - b) : 4;
      w.data = '0;
      for (int k = 0; k < cnt; k++) w.data[8*k +: 8] = pix_buf[b+k];
      w.keep = 4'((1 << cnt) - 1);
      w.last = (b + 4 >= n);
      if (idx < limit) exp_q.push_back(w);
      idx++;
    end
  endfunction

  function automatic void fill_pixels(input int n, input int base, input bit rnd);
    pix_buf.delete();
    for (int i = 0; i < n; i++) pix_buf.push_back(rnd ? 8'($urandom) : 8'(base + i));
  endfunction

  task automatic drive_frame(input int len, input int nsend, input bit gaps);
    @(posedge clk); #1;
    i_start = 1'b1;
    i_frame_pix = 20'(len);
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int i = 0; i < nsend; i++) begin
      while (gaps && $urandom_range(0, 3) == 0) begin
        i_pix_valid = 1'b0;
        @(posedge clk); #1;
      end
      i_pix_valid = 1'b1;
      i_pix = pix_buf[i];
      @(posedge clk); #1;
    end
    i_pix_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 2000 && o_busy; k++) @(negedge clk);
    check("drain_timeout", 64'(o_busy), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid, o_busy, o_done, o_overflow}, 64'd0);
  endtask

  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: m_axis_tready = 1'b0;
        1: m_axis_tready = 1'b1;
        2: m_axis_tready = ~m_axis_tready;
        default: m_axis_tready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_q = 0;
    end else begin
      if (stall_q) begin
        check("stall_valid", 64'(m_axis_tvalid), 64'd1);
        check("stall_stable", 64'({m_axis_tlast, m_axis_tkeep, m_axis_tdata}), 64'(stall_word));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %0h expected no word", m_axis_tdata);
        end else begin
          w_mon = exp_q.pop_front();
          check("tdata", 64'(m_axis_tdata), 64'(w_mon.data));
          check("tkeep", 64'(m_axis_tkeep), 64'(w_mon.keep));
          check("tlast", 64'(m_axis_tlast), 64'(w_mon.last));
        end
        if (m_axis_tlast) hs_cyc = cyc;
      end
      if (o_done) begin
        done_seen++;
        check("done_timing", 64'(cyc), 64'(hs_cyc + 1));
      end
      stall_q = m_axis_tvalid && !m_axis_tready;
      stall_word = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
    end
  end

  initial begin
    int saved_done;
    rst_n = 1'b0;
    i_start = 1'b0;
    i_frame_pix = '0;
    i_pix = '0;
    i_pix_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_state");
    @(posedge clk); #1;
    rst_n = 1'b1;

    ready_mode = 1;
    fill_pixels(8, 1, 0);
    expect_frame(99);
    done_exp++;
    drive_frame(8, 8, 0);
    wait_idle();
    check("ovf_frame8", 64'(o_overflow), 64'd0);

    fill_pixels(6, 8'hA0, 0);
    expect_frame(99);
    done_exp++;
    drive_frame(6, 6, 0);
    wait_idle();

    pix_buf.delete();
    pix_buf.push_back(8'hFF);
    expect_frame(99);
    done_exp++;
    drive_frame(1, 1, 0);
    @(negedge clk);
    check("single_valid", 64'(m_axis_tvalid), 64'd1);
    check("single_keep", 64'(m_axis_tkeep), 64'd1);
    wait_idle();

    ready_mode = 0;
    fill_pixels(24, 1, 0);
    expect_frame(4);
    saved_done = done_seen;
    drive_frame(24, 24, 0);
    @(negedge clk);
    check("ovf_set", 64'(o_overflow), 64'd1);
    check("ovf_held_valid", 64'(m_axis_tvalid), 64'd1);
    check("ovf_head", 64'(m_axis_tdata), 64'h04030201);
    ready_mode = 1;
    wait_idle();
    check("ovf_no_done", 64'(done_seen), 64'(saved_done));
    check("ovf_all_delivered", 64'(exp_q.size()), 64'd0);
    check("ovf_sticky", 64'(o_overflow), 64'd1);

    ready_mode = 2;
    fill_pixels(16, 0, 1);
    expect_frame(99);
    done_exp++;
    drive_frame(16, 16, 0);
    wait_idle();
    check("ovf_cleared", 64'(o_overflow), 64'd0);

    ready_mode = 3;
    for (int f = 0; f < 6; f++) begin
      int n = $urandom_range(1, 40);
      fill_pixels(n, 0, 1);
      expect_frame(99);
      done_exp++;
      drive_frame(n, n, 1);
      wait_idle();
      check("rand_no_ovf", 64'(o_overflow), 64'd0);
    end

    ready_mode = 1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      i_pix_valid = 1'b1;
      i_pix = 8'($urandom);
      i_start = (k % 3 == 0);
      i_frame_pix = '0;
    end
    @(posedge clk); #1;
    i_pix_valid = 1'b0;
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", 64'(o_busy), 64'd0);
    check("idle_valid", 64'(m_axis_tvalid), 64'd0);

    ready_mode = 0;
    fill_pixels(8, 8'h30, 0);
    drive_frame(8, 5, 0);
    check("pre_reset_valid", 64'(m_axis_tvalid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    ready_mode = 1;
    fill_pixels(4, 8'h11, 0);
    expect_frame(99);
    done_exp++;
    drive_frame(4, 4, 0);
    wait_idle();

    check("done_count", 64'(done_seen), 64'(done_exp));
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pixel_packer_axis.md
Name: pixel_packer_axis

Overview:
- Downstream neighbour of the overflow/clamp stage in the editing accelerator.
- Takes one clamped 8-bit pixel per valid cycle and packs four pixels into a 32-bit AXI4-Stream word for the S2MM DMA channel.
- Marks the final word of each frame with tlast and tkeep.
- The clamp stage has no ready, so this block buffers words in a FIFO and flags any data loss as overflow.

Parameters:
- FIFO_DEPTH, 16, number of 32-bit word entries; power of two, minimum 4.
- LEN_W, 20, width of the frame-length (pixel count) input.

Ports:
- clk  in  1  single clock for the whole block.
- rst_n  in  1  reset, asynchronous assert, active-low.
- i_start  in  1  one-cycle pulse that arms a frame.
- i_frame_pix  in  LEN_W  pixels per frame, sampled on i_start.
- i_pix  in  8  clamped pixel from the clamp stage.
- i_pix_valid  in  1  i_pix is valid this cycle.
- m_axis_tdata  out  32  packed word; first pixel of the word in [7:0].
- m_axis_tkeep  out  4  byte-valid mask.
- m_axis_tlast  out  1  last word of the frame.
- m_axis_tvalid  out  1  word available.
- m_axis_tready  in  1  DMA accepts the word.
- o_busy  out  1  frame armed or words still pending.
- o_done  out  1  one-cycle pulse when the tlast word handshakes.
- o_overflow  out  1  sticky; a word was dropped because the FIFO was full.

Behaviour:
- Reset values: all outputs 0, FIFO empty, state IDLE, counters 0.

State machine (IDLE, PACK, DRAIN):
- IDLE:
  - On i_start with i_frame_pix != 0, latch the length, clear o_overflow, clear the lane and pixel counters, then go to PACK.
  - i_start with i_frame_pix == 0 is ignored.
  - Pixels arriving in IDLE are dropped and not counted.
- PACK:
  - Each i_pix_valid writes i_pix into byte lane `lane` (0..3) of the assembly register, increments `lane` and increments the pixel count.
  - When lane 3 is written, or the last pixel of the frame is written, the word is pushed into the FIFO in that same clock edge. The push carries tkeep = lanes filled so far (for example 4'b0011 when 2 pixels remain) and tlast = 1 on the final pixel.
  - Unused lanes of a partial word are 0.
  - After the final pixel, go to DRAIN.
- DRAIN: when the tlast word handshakes (tvalid & tready), pulse o_done for one cycle and go to IDLE.
- i_start in PACK or DRAIN is ignored.
- o_busy = (state != IDLE).

FIFO:
- Show-ahead with registered outputs.
- A word pushed at edge N is visible on m_axis_* (tvalid=1) from cycle N+1.
- Full-rate throughput: one word per cycle when tready is held high.
- Simultaneous push and pop while full: the push is accepted.
- Push while full with no pop: the word is dropped and o_overflow is set. o_overflow stays set until the next accepted i_start or reset.
- If the dropped word carried tlast, the FSM still leaves DRAIN once the FIFO is empty. o_done is not pulsed in this case.

AXI-Stream rules:
- tdata, tkeep and tlast stay stable while tvalid=1 and tready=0.
- tvalid never depends combinationally on tready.

Reset mid-frame: immediate return to IDLE, FIFO flushed, the partial word is discarded.

Counters:
- The pixel count is LEN_W bits, compared against the latched length.
- `lane` is 2 bits and wraps 3 -> 0.

Decomposition:
- Shared package:
  - PIX_W = 8.
  - AXIS_W = 32.
  - LANES = 4.
  - The state encoding (IDLE, PACK, DRAIN) as localparams.
- Sub-module: sync_fifo_fwft, a parameterised width/depth first-word-fall-through FIFO with full/empty flags. It is reused by the other DMA-facing stages.
- Packing and the FSM stay in the top level.

Test Plan:
- Frame of 8 pixels 0x01..0x08, tready=1 -> two words, 0x04030201 (tkeep F, tlast 0) then 0x08070605 (tkeep F, tlast 1); o_done pulses one cycle after the second handshake.
- Frame of 6 pixels 0xA0..0xA5 -> 0xA3A2A1A0 (tkeep F), then 0x0000A5A4 (tkeep 3, tlast 1).
- Frame of 1 pixel 0xFF -> a single word 0x000000FF with tkeep 1, tlast 1, tvalid exactly one cycle after the pixel edge.
- FIFO_DEPTH=4, 24 pixels, tready=0 throughout -> 4 words held, o_overflow=1 after the 5th push. Then tready=1: exactly 4 words delivered with the first still 0x04030201, and no o_done.
- tready toggling every cycle during a 16-pixel frame -> tdata stable while stalled, all 4 words in order, no overflow.
- Pixels plus i_start with i_frame_pix=0 while IDLE -> no output, o_busy=0. Then rst_n pulsed low mid-frame -> all outputs 0 asynchronously; a subsequent 4-pixel frame packs correctly.
